risc_wb_arbiter: RTL

Write-back arbiter for the 32x32 register file's single write port. Two producers, the ALU result path and the load/memory result path, each present a destination register and data. The block buffers one entry per producer, grants the write port to one entry per cycle (oldest first, round-robin on ties), and drives registered write-enable, address and data straight into the register file. It also exports a pending-write mask for decode stall logic and a contention counter for performance debug.

---
 rtl/risc_wb_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/risc_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: one holding entry per
// producer (ALU, load), oldest-first grant with round-robin on equal age, registered RF write.
module risc_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd_5,
    input  logic [31:0] alu_data_32,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd_5,
    input  logic [31:0] mem_data_32,
    output logic        mem_ready,
    output logic        rf_writeEnable,
    output logic [4:0]  rf_writeAddr_5,
    output logic [31:0] rf_writePort_32,
    output logic [31:0] pending_32,
    output logic [15:0] contention_cnt_16
);

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned NREG = 32;

    logic          r_alu_v;
    logic [AW-1:0] r_alu_rd;
    logic [DW-1:0] r_alu_data;
    logic          r_mem_v;
    logic [AW-1:0] r_mem_rd;
    logic [DW-1:0] r_mem_data;
    logic          r_alu_older;
    logic          r_mem_older;
    logic          r_rr_mem;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;

    logic            w_both;
    logic            w_tie;
    logic            w_gnt_alu;
    logic            w_gnt_mem;
    logic            w_alu_cap;
    logic            w_mem_cap;
    logic            w_alu_next;
    logic            w_mem_next;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;
    logic [NREG-1:0] w_pending;

    assign w_both = r_alu_v & r_mem_v;
    assign w_tie  = w_both & ~r_alu_older & ~r_mem_older;

    // Grant: lone entry wins; with both held the older wins, equal age follows rr
    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (w_both) begin
            if (r_alu_older) begin
                w_gnt_alu = 1'b1;
            end else if (r_mem_older) begin
                w_gnt_mem = 1'b1;
            end else if (r_rr_mem) begin
                w_gnt_mem = 1'b1;
            end else begin
                w_gnt_alu = 1'b1;
            end
        end else begin
            w_gnt_alu = r_alu_v;
            w_gnt_mem = r_mem_v;
        end
    end

    assign alu_ready  = ~r_alu_v | w_gnt_alu;
    assign mem_ready  = ~r_mem_v | w_gnt_mem;
    assign w_alu_cap  = alu_valid & alu_ready;
    assign w_mem_cap  = mem_valid & mem_ready;
    assign w_alu_next = w_alu_cap | (r_alu_v & ~w_gnt_alu);
    assign w_mem_next = w_mem_cap | (r_mem_v & ~w_gnt_mem);

    assign w_sel_rd   = w_gnt_mem ? r_mem_rd   : r_alu_rd;
    assign w_sel_data = w_gnt_mem ? r_mem_data : r_alu_data;

    always_comb begin
        w_pending = '0;
        if (r_alu_v) begin
            w_pending[r_alu_rd] = 1'b1;
        end
        if (r_mem_v) begin
            w_pending[r_mem_rd] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    // Holding registers: a granted entry leaves on the same edge a new one may arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_v    <= 1'b0;
            r_alu_rd   <= '0;
            r_alu_data <= '0;
            r_mem_v    <= 1'b0;
            r_mem_rd   <= '0;
            r_mem_data <= '0;
        end else begin
            if (w_alu_cap) begin
                r_alu_v    <= 1'b1;
                r_alu_rd   <= alu_rd_5;
                r_alu_data <= alu_data_32;
            end else if (w_gnt_alu) begin
                r_alu_v <= 1'b0;
            end
            if (w_mem_cap) begin
                r_mem_v    <= 1'b1;
                r_mem_rd   <= mem_rd_5;
                r_mem_data <= mem_data_32;
            end else if (w_gnt_mem) begin
                r_mem_v <= 1'b0;
            end
        end
    end

    // Age: an entry that stays held while the other source captures becomes older
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_older <= 1'b0;
            r_mem_older <= 1'b0;
        end else if (w_alu_next && w_mem_next) begin
            if (w_alu_cap && !w_mem_cap) begin
                r_alu_older <= 1'b0;
                r_mem_older <= 1'b1;
            end else if (w_mem_cap && !w_alu_cap) begin
                r_alu_older <= 1'b1;
                r_mem_older <= 1'b0;
            end else if (w_alu_cap && w_mem_cap) begin
                r_alu_older <= 1'b0;
                r_mem_older <= 1'b0;
            end
        end else begin
            r_alu_older <= 1'b0;
            r_mem_older <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_mem <= 1'b1;
            r_cnt    <= '0;
        end else begin
            if (w_tie) begin
                r_rr_mem <= ~r_rr_mem;
            end
            if (w_both && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Output stage: x0 writes are consumed without enabling the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_gnt_alu || w_gnt_mem) begin
            r_we    <= (w_sel_rd != AW'(0));
            r_waddr <= w_sel_rd;
            r_wdata <= w_sel_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign rf_writeEnable    = r_we;
    assign rf_writeAddr_5    = r_waddr;
    assign rf_writePort_32   = r_wdata;
    assign pending_32        = w_pending;
    assign contention_cnt_16 = r_cnt;

endmodule
